// File: rtl/mc_control_unit.sv
`default_nettype none
// ============================================================================
// mc_control_unit : multicycle RISC-V control FSM (Moore, with memory waits)
// Revision 1.0
// ============================================================================
module mc_control_unit #(
   parameter int ALU_CTRL_W = 3,
   parameter bit BNE_EN     = 1'b1,
   parameter bit JAL_EN     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            op,
   input  logic [2:0]            f3,
   input  logic                  f7,
   input  logic                  zero,
   input  logic                  memReady,
   output logic                  pcWrite,
   output logic                  adrSrc,
   output logic                  memWrite,
   output logic                  irWrite,
   output logic [1:0]            resultSrc,
   output logic [1:0]            aluSrcA,
   output logic [1:0]            aluSrcB,
   output logic [1:0]            immSrc,
   output logic                  regWrite,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  illegal
);

   localparam logic [6:0] c_OP_LW  = 7'b0000011;
   localparam logic [6:0] c_OP_SW  = 7'b0100011;
   localparam logic [6:0] c_OP_R   = 7'b0110011;
   localparam logic [6:0] c_OP_I   = 7'b0010011;
   localparam logic [6:0] c_OP_BR  = 7'b1100011;
   localparam logic [6:0] c_OP_JAL = 7'b1101111;

   localparam logic [2:0] c_ALU_ADD = 3'b000;
   localparam logic [2:0] c_ALU_SUB = 3'b001;
   localparam logic [2:0] c_ALU_AND = 3'b010;
   localparam logic [2:0] c_ALU_OR  = 3'b011;
   localparam logic [2:0] c_ALU_SLT = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   state_t      r_state, w_next;
   logic        w_pc, w_adr, w_mw, w_ir, w_rw, w_ill;
   logic [1:0]  w_rs, w_a, w_b;
   logic [2:0]  w_alu, w_funct_alu;
   logic        w_br_ok, w_is_jal;

   assign w_br_ok  = (f3 == 3'b000) || (BNE_EN && (f3 == 3'b001));
   assign w_is_jal = JAL_EN && (op == c_OP_JAL);

   always_comb begin
      w_funct_alu = c_ALU_ADD;
      case (f3)
         3'b000:  w_funct_alu = ({op[5], f7} == 2'b11) ? c_ALU_SUB : c_ALU_ADD;
         3'b010:  w_funct_alu = c_ALU_SLT;
         3'b110:  w_funct_alu = c_ALU_OR;
         3'b111:  w_funct_alu = c_ALU_AND;
         default: w_funct_alu = c_ALU_ADD;
      endcase
   end

   always_comb begin
      immSrc = 2'b00;
      case (op)
         c_OP_SW:  immSrc = 2'b01;
         c_OP_BR:  immSrc = 2'b10;
         c_OP_JAL: immSrc = 2'b11;
         default:  immSrc = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_pc   = 1'b0;
      w_adr  = 1'b0;
      w_mw   = 1'b0;
      w_ir   = 1'b0;
      w_rw   = 1'b0;
      w_ill  = 1'b0;
      w_rs   = 2'b00;
      w_a    = 2'b00;
      w_b    = 2'b00;
      w_alu  = c_ALU_ADD;
      case (r_state)
         S_FETCH: begin
            w_b  = 2'b10;
            w_rs = 2'b10;
            w_ir = memReady;
            w_pc = memReady;
            if (memReady) w_next = S_DECODE;
         end
         S_DECODE: begin
            // Target (oldPC + imm) lands in ALUOut for BRANCH/JAL to use.
            w_a = 2'b01;
            w_b = 2'b01;
            if ((op == c_OP_LW) || (op == c_OP_SW)) w_next = S_MEMADR;
            else if (op == c_OP_R)                  w_next = S_EXECR;
            else if (op == c_OP_I)                  w_next = S_EXECI;
            else if ((op == c_OP_BR) && w_br_ok)    w_next = S_BRANCH;
            else if (w_is_jal)                      w_next = S_JAL;
            else begin
               w_ill  = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_MEMADR: begin
            w_a    = 2'b10;
            w_b    = 2'b01;
            w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            w_adr = 1'b1;
            if (memReady) w_next = S_MEMWB;
         end
         S_MEMWRITE: begin
            w_adr = 1'b1;
            w_mw  = 1'b1;
            if (memReady) w_next = S_FETCH;
         end
         S_MEMWB: begin
            w_rs   = 2'b01;
            w_rw   = 1'b1;
            w_next = S_FETCH;
         end
         S_EXECR: begin
            w_a    = 2'b10;
            w_alu  = w_funct_alu;
            w_next = S_ALUWB;
         end
         S_EXECI: begin
            w_a    = 2'b10;
            w_b    = 2'b01;
            w_alu  = w_funct_alu;
            w_next = S_ALUWB;
         end
         S_ALUWB: begin
            w_rw   = 1'b1;
            w_next = S_FETCH;
         end
         S_BRANCH: begin
            w_a    = 2'b10;
            w_alu  = c_ALU_SUB;
            w_pc   = zero ^ f3[0];
            w_next = S_FETCH;
         end
         S_JAL: begin
            w_a    = 2'b01;
            w_b    = 2'b10;
            w_pc   = 1'b1;
            w_next = S_ALUWB;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Enables are masked while reset is held so FETCH cannot fire early.
   assign pcWrite   = w_pc  & ~reset;
   assign irWrite   = w_ir  & ~reset;
   assign regWrite  = w_rw  & ~reset;
   assign memWrite  = w_mw  & ~reset;
   assign illegal   = w_ill & ~reset;
   assign adrSrc    = w_adr;
   assign resultSrc = w_rs;
   assign aluSrcA   = w_a;
   assign aluSrcB   = w_b;

   always_comb begin
      ALUControl      = '0;
      ALUControl[2:0] = w_alu;
   end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// ============================================================================
// tb_mc_control_unit : random instruction stream vs. per-instruction schedule
// Revision 1.0
// ============================================================================
module tb_mc_control_unit;

   localparam logic [6:0] c_LW  = 7'b0000011;
   localparam logic [6:0] c_SW  = 7'b0100011;
   localparam logic [6:0] c_R   = 7'b0110011;
   localparam logic [6:0] c_I   = 7'b0010011;
   localparam logic [6:0] c_BR  = 7'b1100011;
   localparam logic [6:0] c_JAL = 7'b1101111;
   localparam logic [6:0] c_LUI = 7'b0110111;
   localparam logic [2:0] c_ADD = 3'b000;
   localparam logic [2:0] c_SUB = 3'b001;

   typedef struct packed {
      logic       pc, adr, mw, ir;
      logic [1:0] rs, a, b;
      logic       rw;
      logic [2:0] alu;
      logic       ill;
   } exp_t;

   logic       clk, reset, f7, zero, memReady;
   logic [6:0] op;
   logic [2:0] f3;

   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
   logic [2:0] ALUControl;

   logic       pcWrite2, adrSrc2, memWrite2, irWrite2, regWrite2, illegal2;
   logic [1:0] resultSrc2, aluSrcA2, aluSrcB2, immSrc2;
   logic [3:0] ALUControl2;

   int   n_chk, n_fail, cyc_cnt, stop_at, n;
   logic chk_en;
   exp_t r_exp;
   logic [6:0] cur_op;
   logic [2:0] cur_f3;
   logic       cur_f7;

   mc_control_unit dut (
      .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
      .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
      .memWrite(memWrite), .irWrite(irWrite), .resultSrc(resultSrc),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .immSrc(immSrc),
      .regWrite(regWrite), .ALUControl(ALUControl), .illegal(illegal)
   );

   mc_control_unit #(.ALU_CTRL_W(4), .BNE_EN(1'b0), .JAL_EN(1'b0)) dut2 (
      .clk(clk), .reset(reset), .op(op), .f3(f3), .f7(f7), .zero(zero),
      .memReady(memReady), .pcWrite(pcWrite2), .adrSrc(adrSrc2),
      .memWrite(memWrite2), .irWrite(irWrite2), .resultSrc(resultSrc2),
      .aluSrcA(aluSrcA2), .aluSrcB(aluSrcB2), .immSrc(immSrc2),
      .regWrite(regWrite2), .ALUControl(ALUControl2), .illegal(illegal2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic pc, adr, mw, ir, input logic [1:0] rs, a, b,
                               input logic rw, input logic [2:0] alu, input logic ill);
      exp_t e;
      e = '{pc: pc, adr: adr, mw: mw, ir: ir, rs: rs, a: a, b: b, rw: rw, alu: alu, ill: ill};
      return e;
   endfunction

   function automatic logic [2:0] funct_alu(input logic op5, input logic b7, input logic [2:0] f);
      case (f)
         3'd0:    return ({op5, b7} == 2'b11) ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == c_SW)  return 2'b01;
      if (o == c_BR)  return 2'b10;
      if (o == c_JAL) return 2'b11;
      return 2'b00;
   endfunction

   // 0 lw, 1 sw, 2 R, 3 I, 4 branch, 5 jal, 6 illegal (default-parameter DUT)
   function automatic int classify(input logic [6:0] o, input logic [2:0] f);
      if (o == c_LW)  return 0;
      if (o == c_SW)  return 1;
      if (o == c_R)   return 2;
      if (o == c_I)   return 3;
      if (o == c_BR)  return (f == 3'd0 || f == 3'd1) ? 4 : 6;
      if (o == c_JAL) return 5;
      return 6;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         n_chk++;
         if ({pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite,
              ALUControl, illegal, immSrc} !== {r_exp, imm_of(op)}) begin
            n_fail++;
            $display("FAIL cycle_outputs t=%0t op=%b f3=%b got=%b required=%b", $time, op, f3,
                     {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite,
                      ALUControl, illegal, immSrc}, {r_exp, imm_of(op)});
         end
      end
   end

   task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s got=%0h required=%0h", nm, got, req);
      end
   endtask

   task automatic step(input logic m, input logic z, input exp_t e);
      if (stop_at != 0 && cyc_cnt >= stop_at) return;
      @(posedge clk);
      #1;
      op = cur_op; f3 = cur_f3; f7 = cur_f7;
      memReady = m; zero = z; r_exp = e; chk_en = 1'b1;
      cyc_cnt++;
   endtask

   task automatic chk_off();
      @(negedge clk);
      #1 chk_en = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1; memReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // fst/mst: stall cycles in FETCH and in the memory-access state (<0 = random)
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic b7,
                            input int fst, input int mst, input int abort, output int ncyc);
      int   kind, nf, nm;
      logic z;
      exp_t e_rd, e_wr;
      cur_op = o; cur_f3 = f; cur_f7 = b7; cyc_cnt = 0; stop_at = abort;
      nf   = (fst < 0) ? int'($urandom_range(0, 2)) : fst;
      nm   = (mst < 0) ? int'($urandom_range(0, 2)) : mst;
      kind = classify(o, f);
      e_rd = mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, c_ADD, 0);
      e_wr = mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, c_ADD, 0);
      repeat (nf) step(1'b0, rb(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, c_ADD, 0));
      step(1'b1, rb(), mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, c_ADD, 0));
      step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, c_ADD, kind == 6));
      case (kind)
         0: begin
            step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, c_ADD, 0));
            repeat (nm) step(1'b0, rb(), e_rd);
            step(1'b1, rb(), e_rd);
            step(rb(), rb(), mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, c_ADD, 0));
         end
         1: begin
            step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, c_ADD, 0));
            repeat (nm) step(1'b0, rb(), e_wr);
            step(1'b1, rb(), e_wr);
         end
         2, 3: begin
            step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b10, (kind == 3) ? 2'b01 : 2'b00, 0,
                                funct_alu(o[5], b7, f), 0));
            step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, c_ADD, 0));
         end
         4: begin
            z = rb();
            step(rb(), z, mk(z ^ f[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, c_SUB, 0));
         end
         5: begin
            step(rb(), rb(), mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, c_ADD, 0));
            step(rb(), rb(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, c_ADD, 0));
         end
         default: ;
      endcase
      ncyc = cyc_cnt;
      stop_at = 0;
   endtask

   initial begin
      logic [6:0] o;
      logic [2:0] f;
      n_chk = 0; n_fail = 0; chk_en = 1'b0; stop_at = 0; cyc_cnt = 0;
      cur_op = c_LW; cur_f3 = 3'd2; cur_f7 = 1'b0; r_exp = '0;
      reset = 1'b1; memReady = 1'b1; op = c_LW; f3 = 3'd2; f7 = 1'b0; zero = 1'b0;
      #3;
      lit("reset_enables", {pcWrite, irWrite, regWrite, memWrite, illegal}, 0);
      lit("reset_enables_cfg2", {pcWrite2, irWrite2, regWrite2, memWrite2, illegal2}, 0);
      apply_reset();

      // Reduced configuration: bne and jal are illegal, ALUControl is 4 bits.
      memReady = 1'b1; op = c_BR; f3 = 3'b001; zero = 1'b1;
      #3 lit("cfg2_fetch_ir", irWrite2, 1);
      @(posedge clk); #1 lit("cfg2_bne_illegal", illegal2, 1);
      @(posedge clk); #1 lit("cfg2_bne_back_fetch", {irWrite2, illegal2}, 2'b10);
      op = c_JAL;
      @(posedge clk); #1 lit("cfg2_jal_illegal", {illegal2, regWrite2, pcWrite2}, 3'b100);
      @(posedge clk); #1 lit("cfg2_jal_back_fetch", irWrite2, 1);
      op = c_BR; f3 = 3'b000;
      @(posedge clk); #1 lit("cfg2_beq_decode", illegal2, 0);
      @(posedge clk); #1 lit("cfg2_beq_branch", {pcWrite2, ALUControl2}, 5'b1_0001);
      apply_reset();

      // Latencies with no stalls.
      run_instr(c_LW,  3'd2, 1'b0, 0, 0, 0, n); lit("lat_lw", n, 5);
      run_instr(c_SW,  3'd2, 1'b0, 0, 0, 0, n); lit("lat_sw", n, 4);
      run_instr(c_R,   3'd0, 1'b1, 0, 0, 0, n); lit("lat_sub", n, 4);
      run_instr(c_I,   3'd0, 1'b1, 0, 0, 0, n); lit("lat_addi", n, 4);
      run_instr(c_BR,  3'd0, 1'b0, 0, 0, 0, n); lit("lat_branch", n, 3);
      run_instr(c_JAL, 3'd0, 1'b0, 0, 0, 0, n); lit("lat_jal", n, 4);
      run_instr(c_LUI, 3'd0, 1'b0, 0, 0, 0, n); lit("lat_illegal", n, 2);
      run_instr(c_SW,  3'd2, 1'b0, 0, 2, 0, n); lit("lat_sw_wait2", n, 6);

      // Asynchronous reset inside MEMREAD, then a clean lw.
      run_instr(c_LW, 3'd2, 1'b0, 0, 0, 4, n);
      chk_off();
      memReady = 1'b1; reset = 1'b1;
      #1 lit("rst_mid_memread", {pcWrite, irWrite, regWrite, memWrite, illegal, adrSrc}, 0);
      @(posedge clk); #1 memReady = 1'b0; reset = 1'b0;
      run_instr(c_LW, 3'd2, 1'b0, 0, 0, 0, n); lit("lw_after_reset", n, 5);

      // Asynchronous reset inside MEMWRITE.
      run_instr(c_SW, 3'd2, 1'b0, 0, 0, 4, n);
      chk_off();
      memReady = 1'b1; reset = 1'b1;
      #1 lit("rst_mid_memwrite", {memWrite, pcWrite, irWrite, regWrite, illegal}, 0);
      @(posedge clk); #1 memReady = 1'b0; reset = 1'b0;

      for (int k = 0; k < 300; k++) begin
         f = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: o = c_LW;
            1: o = c_SW;
            2: o = c_R;
            3: o = c_I;
            4: begin
               o = c_BR;
               if ($urandom_range(0, 3) != 0) f = {2'b00, rb()};
            end
            5: o = c_JAL;
            6: o = c_LUI;
            default: begin
               o = 7'($urandom_range(0, 127));
               while (o == c_LW || o == c_SW || o == c_R || o == c_I || o == c_BR || o == c_JAL)
                  o = 7'($urandom_range(0, 127));
            end
         endcase
         run_instr(o, f, rb(), -1, -1, 0, n);
      end
      chk_off();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle RISC-V control unit: a Moore FSM that sequences each instruction over 3–5 clocks. It drives the shared-memory / single-ALU datapath that follows the single-cycle core. It generalises the single-cycle decoder in three ways:

- parametrised ALU-control width and optional `bne`/`jal` support;
- memory wait-state handshaking;
- illegal-opcode flagging.

## Interface

Parameters:
- `ALU_CTRL_W`, default 3: width of `ALUControl`. Must be ≥3; bits above [2] are always 0.
- `BNE_EN`, default 1: when 1, `bne` (f3=001) is decoded; when 0, a branch with f3=001 is illegal.
- `JAL_EN`, default 1: when 1, `jal` (op 1101111) is decoded; when 0, `jal` is illegal.

Ports (outputs not listed as combinational are registered-state Moore outputs):
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `op` input 7: opcode from the instruction register.
- `f3` input 3: funct3.
- `f7` input 1: funct7[5].
- `zero` input 1: ALU zero flag.
- `memReady` input 1: memory access completes this cycle.
- `pcWrite` output 1: PC register enable.
- `adrSrc` output 1: memory address select. 0 = PC, 1 = result.
- `memWrite` output 1: memory write enable.
- `irWrite` output 1: instruction and oldPC register enable.
- `resultSrc` output 2: result mux select. 00 = ALUOut, 01 = data, 10 = ALU result.
- `aluSrcA` output 2: ALU operand A select. 00 = PC, 01 = oldPC, 10 = rd1.
- `aluSrcB` output 2: ALU operand B select. 00 = rd2, 01 = immExt, 10 = 4.
- `immSrc` output 2, combinational from `op`: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `regWrite` output 1: register-file write enable.
- `ALUControl` output `ALU_CTRL_W`: ALU operation.
- `illegal` output 1: one-cycle pulse in DECODE when the opcode or funct3 is unsupported.

## Operation

States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.

State transitions:
- FETCH → DECODE when `memReady`=1; otherwise stay in FETCH.
- DECODE → next state by opcode:
  - lw (0000011) or sw (0100011) → MEMADR.
  - R-type (0110011) → EXECR.
  - I-ALU (0010011) → EXECI.
  - branch (1100011) → BRANCH.
  - jal → JAL.
  - anything else → FETCH with `illegal`=1.
- MEMADR → MEMREAD if `op[5]`=0; → MEMWRITE if `op[5]`=1.
- MEMREAD → MEMWB when `memReady`=1; otherwise stay.
- MEMWRITE → FETCH when `memReady`=1; otherwise stay.
- EXECR and EXECI → ALUWB. JAL → ALUWB.
- MEMWB, ALUWB and BRANCH → FETCH.

Outputs per state (any signal not listed is 0):
- FETCH: `adrSrc`=0, `aluSrcA`=00, `aluSrcB`=10, ALU add, `resultSrc`=10. `irWrite` and `pcWrite` are high only when `memReady`=1.
- DECODE: `aluSrcA`=01, `aluSrcB`=01, ALU add. This computes the branch/jump target into ALUOut.
- MEMADR: `aluSrcA`=10, `aluSrcB`=01, ALU add.
- MEMREAD: `adrSrc`=1, `resultSrc`=00.
- MEMWRITE: `adrSrc`=1, `resultSrc`=00, `memWrite`=1. `memWrite` is held high for every cycle spent in MEMWRITE.
- MEMWB: `resultSrc`=01, `regWrite`=1.
- EXECR: `aluSrcA`=10, `aluSrcB`=00, funct decode.
- EXECI: `aluSrcA`=10, `aluSrcB`=01, funct decode.
- ALUWB: `resultSrc`=00, `regWrite`=1.
- BRANCH: `aluSrcA`=10, `aluSrcB`=00, ALU sub, `resultSrc`=00. `pcWrite` = `zero` XOR `f3[0]`. f3 is 000 for beq and 001 for bne.
- JAL: `aluSrcA`=01, `aluSrcB`=10, ALU add, `resultSrc`=00, `pcWrite`=1.

ALUControl encoding:
- 000 add, 001 sub, 010 and, 011 or, 101 slt.

Funct decode (EXECR / EXECI):
- f3=000 → sub if {`op[5]`,`f7`}=11, else add.
- f3=010 → slt.
- f3=110 → or.
- f3=111 → and.
- Any other f3 → add (no illegal flag in execute states).

`immSrc` by opcode:
- lw and I-ALU → 00.
- sw → 01.
- branch → 10.
- jal → 11.
- anything else → 00.

## Timing

- Reset: asynchronous assertion forces FETCH immediately. While `reset`=1, `pcWrite`, `irWrite`, `regWrite`, `memWrite` and `illegal` are forced to 0. After reset is released, the first FETCH cycle is active on the next edge.
- Latency with `memReady` held at 1:
  - lw 5 cycles, sw 4, R-type 4, I-ALU 4, branch 3, jal 4.
- Each cycle with `memReady`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No other state looks at `memReady`.
- In BRANCH, `pcWrite` depends on the current `zero` (Mealy term). All other outputs depend only on state, plus `op`/`f3`/`f7` for ALU decode.
- `illegal` is high for exactly the one DECODE cycle. No state change other than returning to FETCH.
- Reset asserted mid-instruction (e.g. in MEMWRITE): `memWrite` drops the same cycle. Execution resumes in FETCH; no partial writeback occurs.

## Test plan

- Reset then lw, `memReady`=1: states FETCH→DECODE→MEMADR→MEMREAD→MEMWB. `regWrite`=1 only in cycle 5 with `resultSrc`=01.
- sw with `memReady` low for 2 cycles in MEMWRITE: `memWrite`=1 for exactly 3 cycles, then FETCH.
- R-type sub (f3=000, f7=1, op=0110011): `ALUControl`=001 in EXECR. Same with op=0010011: `ALUControl`=000 (addi).
- Branches: beq with `zero`=1 → `pcWrite`=1 in BRANCH. bne with `zero`=1 → `pcWrite`=0. Repeat with `BNE_EN`=0: bne gives `illegal`=1 and returns to FETCH after 2 cycles.
- jal (`JAL_EN`=1): FETCH/DECODE/JAL/ALUWB, `pcWrite` in JAL, `regWrite` in ALUWB. Opcode 0110111 → `illegal` pulse, no `regWrite`.
- Assert `reset` asynchronously mid-MEMREAD: all enables are 0 within the same cycle. State is FETCH; next lw completes normally.
